// File: rtl/condflow_pkg.sv
// condflow_pkg: shared types and helpers for the conditional select sink.
//   state_e   - transaction FSM states
//   sw_width  - width of a channel-select index for m channels (never below 1)
package condflow_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    OUT_REQ,
    OUT_REL,
    ACK
  } state_e;

  function automatic int sw_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cond_select_sink_sat_counter.sv
// sat_counter: counter that increments on inc and holds at its all-ones value.
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears the count
//   inc   - increment request, sampled on clk
//   cnt_o - current count
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cond_select_sink.sv
// cond_select_sink: takes one token from a control-selected 4-phase input
// channel per control handshake, and either forwards it to a 4-phase output
// or discards it (counting discards).
//   clk, rst          - clock; asynchronous active-low reset
//   r_i / a_i         - per-channel request / acknowledge (M channels)
//   d_i               - bundled channel data, channel k at [k*N +: N]
//   ctl_r / ctl_a     - control request / acknowledge
//   ctl_sel, ctl_drop - channel index and discard flag, valid with ctl_r
//   r_o / a_o / d_o   - output request / acknowledge / registered data
//   drop_cnt          - saturating count of discarded tokens
//   err               - sticky out-of-range select flag
module cond_select_sink
  import condflow_pkg::*;
#(
  parameter int  N  = 32,
  parameter int  M  = 2,
  parameter int  CW = 16,
  localparam int SW = sw_width(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M-1:0]    r_i,
  output logic [M-1:0]    a_i,
  input  logic [M*N-1:0]  d_i,
  input  logic            ctl_r,
  output logic            ctl_a,
  input  logic [SW-1:0]   ctl_sel,
  input  logic            ctl_drop,
  output logic            r_o,
  input  logic            a_o,
  output logic [N-1:0]    d_o,
  output logic [CW-1:0]   drop_cnt,
  output logic            err
);

  state_e        state_q;
  logic [SW-1:0] sel_q;
  logic          drop_q;
  logic [M-1:0]  a_q;
  logic          ctl_a_q;
  logic          r_o_q;
  logic [N-1:0]  d_q;
  logic          err_q;

  logic          sel_ok;
  logic          r_sel;
  logic [M-1:0]  sel_onehot;
  logic          drop_inc;

  assign sel_ok = int'(ctl_sel) < M;

  // An out-of-range sel_q matches no channel, so r_sel reads 0 and the
  // one-hot ack is empty; the invalid-select path needs no extra flag.
  always_comb begin
    r_sel      = 1'b0;
    sel_onehot = '0;
    for (int k = 0; k < M; k++) begin
      if (k == int'(sel_q)) begin
        r_sel         = r_i[k];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  assign drop_inc = (state_q == WAIT_IN) && r_sel && drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      drop_q  <= 1'b0;
      a_q     <= '0;
      ctl_a_q <= 1'b0;
      r_o_q   <= 1'b0;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctl_r) begin
            sel_q  <= ctl_sel;
            drop_q <= ctl_drop;
            if (!sel_ok) begin
              // Complete the control handshake without touching any input.
              err_q   <= 1'b1;
              ctl_a_q <= 1'b1;
              state_q <= ACK;
            end else begin
              state_q <= WAIT_IN;
            end
          end
        end
        WAIT_IN: begin
          if (r_sel) begin
            if (drop_q) begin
              ctl_a_q <= 1'b1;
              a_q     <= sel_onehot;
              state_q <= ACK;
            end else begin
              d_q     <= d_i[int'(sel_q)*N +: N];
              r_o_q   <= 1'b1;
              state_q <= OUT_REQ;
            end
          end
        end
        OUT_REQ: begin
          if (a_o) begin
            r_o_q   <= 1'b0;
            state_q <= OUT_REL;
          end
        end
        OUT_REL: begin
          if (!a_o) begin
            ctl_a_q <= 1'b1;
            a_q     <= sel_onehot;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!ctl_r && !r_sel) begin
            ctl_a_q <= 1'b0;
            a_q     <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_counter #(
    .CW(CW)
  ) u_drop_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (drop_inc),
    .cnt_o(drop_cnt)
  );

  assign a_i   = a_q;
  assign ctl_a = ctl_a_q;
  assign r_o   = r_o_q;
  assign d_o   = d_q;
  assign err   = err_q;

endmodule

// File: tb/tb_cond_select_sink.sv
module tb_cond_select_sink;

  localparam int N  = 8;
  localparam int M  = 3;
  localparam int CW = 2;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [M-1:0]   r_i;
  logic [M-1:0]   a_i;
  logic [M*N-1:0] d_i;
  logic           ctl_r;
  logic           ctl_a;
  logic [SW-1:0]  ctl_sel;
  logic           ctl_drop;
  logic           r_o;
  logic           a_o;
  logic [N-1:0]   d_o;
  logic [CW-1:0]  drop_cnt;
  logic           err;

  always #5 clk = ~clk;

  cond_select_sink #(.N(N), .M(M), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .r_i     (r_i),
    .a_i     (a_i),
    .d_i     (d_i),
    .ctl_r   (ctl_r),
    .ctl_a   (ctl_a),
    .ctl_sel (ctl_sel),
    .ctl_drop(ctl_drop),
    .r_o     (r_o),
    .a_o     (a_o),
    .d_o     (d_o),
    .drop_cnt(drop_cnt),
    .err     (err)
  );

  int            n_vec  = 0;
  int            n_fail = 0;
  logic [N-1:0]  sb_q[$];
  logic          exp_err;
  logic [CW-1:0] exp_cnt;

  typedef struct {
    int             sel;
    bit             drop;
    logic [M*N-1:0] dv;
    logic [M-1:0]   pend;  // extra unselected requests held high
    int             rel;   // 0: ctl_r first, 1: r_i first, 2: together
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full control transaction; starts and ends just after a negedge.
  task automatic txn(input int idx, input vec_t v);
    bit           valid;
    bit           fwd;
    bit           seen_ro;
    int           n;
    logic [M-1:0] sel_bit;
    logic [N-1:0] want;
    valid   = (v.sel < M);
    fwd     = valid && !v.drop;
    sel_bit = valid ? (M'(1) << v.sel) : '0;
    want    = valid ? v.dv[v.sel*N +: N] : '0;
    if (fwd) sb_q.push_back(want);

    d_i      = v.dv;
    ctl_sel  = SW'(v.sel);
    ctl_drop = v.drop;
    ctl_r    = 1'b1;
    r_i      = v.pend | sel_bit;

    n       = 0;
    seen_ro = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (r_o) seen_ro = 1'b1;
      if (n == 1 && !ctl_a) begin
        // selection already latched: these must not disturb the transaction
        ctl_sel  = SW'(v.sel + 1);
        ctl_drop = ~v.drop;
      end
    end while (!r_o && !ctl_a && n < 10);

    if (fwd) begin
      chk("fwd_latency", n, 2);
      chk("fwd_r_o", r_o, 1);
      chk("sb_size", sb_q.size(), 1);
      if (sb_q.size() != 0) chk("fwd_d_o", d_o, sb_q.pop_front());
      chk("outreq_a_i", a_i, 0);
      chk("outreq_ctl_a", ctl_a, 0);
      d_i = ~v.dv;
      a_o = 1'b1;
      @(negedge clk);
      chk("outrel_r_o", r_o, 0);
      chk("outrel_d_o", d_o, want);
      a_o = 1'b0;
      @(negedge clk);
    end else begin
      chk("nofwd_r_o", seen_ro, 0);
      chk("ack_latency", n, valid ? 2 : 1);
    end
    chk("ack_ctl_a", ctl_a, 1);
    chk("ack_a_i", a_i, sel_bit);

    if (valid && v.rel == 0) begin
      ctl_r = 1'b0;
      @(negedge clk);
      chk("hold_ctl_a_r", ctl_a, 1);
      r_i = v.pend;
    end else if (valid && v.rel == 1) begin
      r_i = v.pend;
      @(negedge clk);
      chk("hold_ctl_a_c", ctl_a, 1);
      chk("hold_a_i_c", a_i, sel_bit);
      ctl_r = 1'b0;
    end else begin
      ctl_r = 1'b0;
      r_i   = v.pend;
    end
    @(negedge clk);
    chk("idle_ctl_a", ctl_a, 0);
    chk("idle_a_i", a_i, 0);

    if (!valid) exp_err = 1'b1;
    if (valid && v.drop && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    chk("err", err, exp_err);
    chk("drop_cnt", drop_cnt, exp_cnt);
    $display("txn %0d sel=%0d drop=%0d d_o=%0h drop_cnt=%0d err=%0d",
             idx, v.sel, v.drop, d_o, drop_cnt, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1, 1'b0, 24'h00A53C, 3'b000, 0};
    tbl[1]  = '{0, 1'b1, 24'h112233, 3'b000, 1};
    tbl[2]  = '{0, 1'b1, 24'h445566, 3'b000, 2};
    tbl[3]  = '{0, 1'b1, 24'h778899, 3'b000, 0};
    tbl[4]  = '{2, 1'b1, 24'hAABBCC, 3'b000, 1};
    tbl[5]  = '{2, 1'b1, 24'hDDEEFF, 3'b000, 2};
    tbl[6]  = '{3, 1'b0, 24'h123456, 3'b000, 0};
    tbl[7]  = '{2, 1'b0, 24'h5A0000, 3'b000, 1};
    tbl[8]  = '{1, 1'b0, 24'h00C30F, 3'b001, 2};
    tbl[9]  = '{0, 1'b0, 24'h0000E7, 3'b000, 0};
    tbl[10] = '{0, 1'b0, 24'h000081, 3'b000, 1};

    rst      = 1'b0;
    r_i      = '0;
    d_i      = '0;
    ctl_r    = 1'b0;
    ctl_sel  = '0;
    ctl_drop = 1'b0;
    a_o      = 1'b0;
    exp_err  = 1'b0;
    exp_cnt  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_r_o", r_o, 0);
    chk("rst_a_i", a_i, 0);
    chk("rst_ctl_a", ctl_a, 0);
    chk("rst_d_o", d_o, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) txn(i, tbl[i]);

    // Reset asserted mid-transaction while in OUT_REQ.
    d_i      = 24'h0000C3;
    ctl_sel  = 2'd0;
    ctl_drop = 1'b0;
    ctl_r    = 1'b1;
    r_i      = 3'b001;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_r_o", r_o, 1);
    chk("pre_rst_d_o", d_o, 8'hC3);
    #2 rst = 1'b0;
    #1;
    chk("async_r_o", r_o, 0);
    chk("async_a_i", a_i, 0);
    chk("async_ctl_a", ctl_a, 0);
    chk("async_d_o", d_o, 0);
    chk("async_drop_cnt", drop_cnt, 0);
    chk("async_err", err, 0);
    r_i     = '0;
    ctl_r   = 1'b0;
    a_o     = 1'b0;
    exp_err = 1'b0;
    exp_cnt = '0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn(10, tbl[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
